cpu_bus_capture: RTL and testbench

- Upstream front end of the vicii core on the CPU side. Runs in the clk_dot4x domain.
- Synchronizes and filters the asynchronous CPU bus strobes ce and rw, and tracks the phase of clk_phi.
- Issues exactly one clean register-read or register-write strobe per CPU phi cycle, with latched address and data, for the register file inside vicii.
- Also supplies the ls245 data-direction timing reference (bus_busy).

---
 rtl/cpu_bus_capture_if.sv | 30 +++
 rtl/cpu_bus_capture.sv | 197 +++++++++++++++++++
 tb/tb_cpu_bus_capture.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_capture_if.sv
// CPU-side bus bundle for cpu_bus_capture: raw CPU strobes in, clean register strobes out.
interface cpu_bus_capture_if;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned TICK_W = 5;

  logic              clk_phi;
  logic              ce;
  logic              rw;
  logic              aec;
  logic [ADDR_W-1:0] adi;
  logic [DATA_W-1:0] dbi;
  logic [TICK_W-1:0] phi_tick;
  logic              reg_rd;
  logic              reg_wr;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_data;
  logic              reg_unmapped;
  logic              bus_busy;

  modport master (
    output clk_phi, ce, rw, aec, adi, dbi,
    input  phi_tick, reg_rd, reg_wr, reg_addr, reg_data, reg_unmapped, bus_busy
  );

  modport slave (
    input  clk_phi, ce, rw, aec, adi, dbi,
    output phi_tick, reg_rd, reg_wr, reg_addr, reg_data, reg_unmapped, bus_busy
  );
endinterface

// File: rtl/cpu_bus_capture.sv
// CPU bus front end: syncs/filters ce and rw, tracks phi phase, issues one register strobe per phi cycle.
// Optional error counter output enabled by defining CPU_BUS_ERR_COUNT_EN.
module cpu_bus_capture #(
  parameter int unsigned READ_TICK   = 4,
  parameter int unsigned SAMPLE_TICK = 12,
  parameter int unsigned CE_FILTER   = 2
) (
  input  logic                clk_dot4x,
  input  logic                rst,
  cpu_bus_capture_if.slave    bus
`ifdef CPU_BUS_ERR_COUNT_EN
  ,
  output logic [7:0]          err_count
`endif
);

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned TICK_W = 5;
  localparam int unsigned CNT_W  = (CE_FILTER > 1) ? $clog2(CE_FILTER) : 1;

  typedef enum logic [2:0] {IDLE, ARMED, RD_HOLD, WR_WAIT, DONE} state_e;

  state_e              state_q, state_d;
  logic                ce_s1_q, ce_s1_d, ce_s2_q, ce_s2_d;
  logic                rw_s1_q, rw_s1_d, rw_s2_q, rw_s2_d;
  logic                ce_f_q, ce_f_d;
  logic [CNT_W-1:0]    ce_cnt_q, ce_cnt_d;
  logic                phi_d_q, phi_d_d;
  logic [TICK_W-1:0]   phi_tick_q, phi_tick_d;
  logic                reg_rd_q, reg_rd_d;
  logic                reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]   reg_data_q, reg_data_d;
  logic                reg_unmapped_q, reg_unmapped_d;
  logic                bus_busy_q, bus_busy_d;
  logic                phi_rise_c;
  logic                unmapped_c;
`ifdef CPU_BUS_ERR_COUNT_EN
  logic                err_ev;
  logic [7:0]          err_count_q, err_count_d;
`endif

  assign phi_rise_c = bus.clk_phi & ~phi_d_q;
  assign unmapped_c = (bus.adi >= 6'h2F);

  // Synchronizers, ce glitch filter and phi phase counter
  always_comb begin
    ce_s1_d    = bus.ce;
    ce_s2_d    = ce_s1_q;
    rw_s1_d    = bus.rw;
    rw_s2_d    = rw_s1_q;
    ce_f_d     = ce_f_q;
    ce_cnt_d   = '0;
    phi_d_d    = bus.clk_phi;
    phi_tick_d = phi_tick_q;
    if (ce_s2_q != ce_f_q) begin
      if (ce_cnt_q == CNT_W'(CE_FILTER - 1)) ce_f_d = ce_s2_q;
      else                                   ce_cnt_d = ce_cnt_q + CNT_W'(1);
    end
    if (phi_rise_c)                    phi_tick_d = '0;
    else if (phi_tick_q != 5'd31)      phi_tick_d = phi_tick_q + 5'd1;
  end

  // Access FSM: one read or write decision per phi high phase
  always_comb begin
    state_d        = state_q;
    reg_rd_d       = 1'b0;
    reg_wr_d       = 1'b0;
    reg_addr_d     = reg_addr_q;
    reg_data_d     = reg_data_q;
    reg_unmapped_d = reg_unmapped_q;
    bus_busy_d     = bus_busy_q;
`ifdef CPU_BUS_ERR_COUNT_EN
    err_ev         = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (phi_rise_c) state_d = ARMED;
      end
      ARMED: begin
        if (!bus.clk_phi) begin
          state_d = IDLE;
        end else if (phi_tick_q == TICK_W'(READ_TICK)) begin
          if (!ce_f_q && bus.aec) begin
            if (rw_s2_q) begin
              reg_rd_d       = 1'b1;
              reg_addr_d     = bus.adi;
              reg_unmapped_d = unmapped_c;
              bus_busy_d     = 1'b1;
              state_d        = RD_HOLD;
            end else begin
              state_d = WR_WAIT;
            end
          end else begin
            state_d = DONE;
          end
        end
      end
      WR_WAIT: begin
        if (!bus.clk_phi) begin
          state_d = IDLE;
`ifdef CPU_BUS_ERR_COUNT_EN
          err_ev  = 1'b1;
`endif
        end else if (phi_tick_q == TICK_W'(SAMPLE_TICK)) begin
          state_d = DONE;
          if (!ce_f_q && !rw_s2_q) begin
            reg_wr_d       = 1'b1;
            reg_addr_d     = bus.adi;
            reg_data_d     = bus.dbi;
            reg_unmapped_d = unmapped_c;
          end else begin
`ifdef CPU_BUS_ERR_COUNT_EN
            err_ev = 1'b1;
`endif
          end
        end
      end
      RD_HOLD, DONE: begin
        // A rise here means the low phase was missed; re-arm straight away
        if (phi_rise_c) begin
          state_d    = ARMED;
          bus_busy_d = 1'b0;
        end else if (!bus.clk_phi) begin
          state_d    = IDLE;
          bus_busy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CPU_BUS_ERR_COUNT_EN
  // Saturating error counter, cleared by a write to the last register slot
  always_comb begin
    err_count_d = err_count_q;
    if (reg_wr_d && (bus.adi == 6'h3F))      err_count_d = '0;
    else if (err_ev && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end
  assign err_count = err_count_q;
`else
  // Error events are not tracked in this build.
`endif

  // phi_d resets high so a reset inside phi high does not fake a rise
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      state_q        <= IDLE;
      ce_s1_q        <= 1'b1;
      ce_s2_q        <= 1'b1;
      rw_s1_q        <= 1'b1;
      rw_s2_q        <= 1'b1;
      ce_f_q         <= 1'b1;
      ce_cnt_q       <= '0;
      phi_d_q        <= 1'b1;
      phi_tick_q     <= '0;
      reg_rd_q       <= 1'b0;
      reg_wr_q       <= 1'b0;
      reg_addr_q     <= '0;
      reg_data_q     <= '0;
      reg_unmapped_q <= 1'b0;
      bus_busy_q     <= 1'b0;
`ifdef CPU_BUS_ERR_COUNT_EN
      err_count_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ce_s1_q        <= ce_s1_d;
      ce_s2_q        <= ce_s2_d;
      rw_s1_q        <= rw_s1_d;
      rw_s2_q        <= rw_s2_d;
      ce_f_q         <= ce_f_d;
      ce_cnt_q       <= ce_cnt_d;
      phi_d_q        <= phi_d_d;
      phi_tick_q     <= phi_tick_d;
      reg_rd_q       <= reg_rd_d;
      reg_wr_q       <= reg_wr_d;
      reg_addr_q     <= reg_addr_d;
      reg_data_q     <= reg_data_d;
      reg_unmapped_q <= reg_unmapped_d;
      bus_busy_q     <= bus_busy_d;
`ifdef CPU_BUS_ERR_COUNT_EN
      err_count_q    <= err_count_d;
`endif
    end
  end

  assign bus.phi_tick     = phi_tick_q;
  assign bus.reg_rd       = reg_rd_q;
  assign bus.reg_wr       = reg_wr_q;
  assign bus.reg_addr     = reg_addr_q;
  assign bus.reg_data     = reg_data_q;
  assign bus.reg_unmapped = reg_unmapped_q;
  assign bus.bus_busy     = bus_busy_q;

endmodule

// File: tb/tb_cpu_bus_capture.sv
// Scoreboard bench for cpu_bus_capture; err_count checks active when CPU_BUS_ERR_COUNT_EN is defined.
module tb_cpu_bus_capture;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [5:0] addr;
    logic [7:0] data;
    logic       unm;
    logic [4:0] tick;
    logic       busy;
  } strobe_t;

  logic clk;
  logic rst;
  int   pc;
  int   n_vec;
  int   n_fail;
  logic [7:0] wdata_m;
  logic [7:0] err_exp;
  strobe_t exp_q[$];
  strobe_t obs_q[$];

  cpu_bus_capture_if bus();
`ifdef CPU_BUS_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  cpu_bus_capture dut (
    .clk_dot4x (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef CPU_BUS_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // phi: pc 0..15 high, 16..31 low; updated on the falling edge
  initial begin
    pc = 20;
    bus.clk_phi = 1'b0;
    forever begin
      @(negedge clk);
      pc = (pc + 1) % 32;
      bus.clk_phi = (pc < 16);
    end
  end

  // Strobe monitor: records every strobe the DUT emits
  always @(posedge clk) begin
    #1;
    if (bus.reg_rd || bus.reg_wr)
      obs_q.push_back('{rd: bus.reg_rd, wr: bus.reg_wr, addr: bus.reg_addr, data: bus.reg_data,
                        unm: bus.reg_unmapped, tick: bus.phi_tick, busy: bus.bus_busy});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pc(input int n);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (pc != n && k < 64);
    if (pc != n) begin
      n_vec++;
      n_fail++;
      $display("FAIL wait_pc: got pc %0d want %0d", pc, n);
    end
  endtask

  task automatic start_access(input logic ce_v, input logic rw_v, input logic aec_v,
                              input logic [5:0] a, input logic [7:0] d);
    wait_pc(26);
    bus.ce  = ce_v;
    bus.rw  = rw_v;
    bus.aec = aec_v;
    bus.adi = a;
    bus.dbi = d;
  endtask

  task automatic end_access();
    wait_pc(17);
    bus.ce  = 1'b1;
    bus.rw  = 1'b1;
    bus.aec = 1'b0;
  endtask

  task automatic push_wr(input logic [5:0] a, input logic [7:0] d);
    exp_q.push_back('{rd: 1'b0, wr: 1'b1, addr: a, data: d, unm: (a >= 6'h2F), tick: 5'd13, busy: 1'b0});
    wdata_m = d;
  endtask

  task automatic push_rd(input logic [5:0] a);
    exp_q.push_back('{rd: 1'b1, wr: 1'b0, addr: a, data: wdata_m, unm: (a >= 6'h2F), tick: 5'd5, busy: 1'b1});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ce = 1'b1; bus.rw = 1'b1; bus.aec = 1'b0; bus.adi = '0; bus.dbi = '0;
    repeat (4) step();
    rst = 1'b0;
    wdata_m = '0;
    err_exp = '0;
    n_vec++;
    if ({bus.reg_rd, bus.reg_wr, bus.reg_unmapped, bus.bus_busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset strobes: got %b want 0000", {bus.reg_rd, bus.reg_wr, bus.reg_unmapped, bus.bus_busy});
    end
    n_vec++;
    if ({bus.reg_addr, bus.reg_data, bus.phi_tick} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset regs: got addr %h data %h tick %0d want 0", bus.reg_addr, bus.reg_data, bus.phi_tick);
    end
`ifdef CPU_BUS_ERR_COUNT_EN
    n_vec++;
    if (err_count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset err_count: got %h want 00", err_count);
    end
`endif
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_write();
    strobe_t e, o;
    start_access(1'b0, 1'b0, 1'b1, 6'h20, 8'hA5);
    push_wr(6'h20, 8'hA5);
    end_access();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL write count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_fail++; $display("FAIL write strobe: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_read();
    strobe_t e, o;
    start_access(1'b0, 1'b1, 1'b1, 6'h12, 8'hFF);
    push_rd(6'h12);
    wait_pc(15);
    n_vec++;
    if (bus.bus_busy !== 1'b1) begin n_fail++; $display("FAIL read busy_hi: got %b want 1", bus.bus_busy); end
    wait_pc(16);
    n_vec++;
    if (bus.bus_busy !== 1'b0) begin n_fail++; $display("FAIL read busy_lo: got %b want 0", bus.bus_busy); end
    end_access();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL read count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_fail++; $display("FAIL read strobe: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    wait_pc(3);
    bus.ce = 1'b0; bus.rw = 1'b0; bus.aec = 1'b1;
    step();
    bus.ce = 1'b1;
    wait_pc(10);
    n_vec++;
    if (bus.phi_tick !== 5'd10) begin n_fail++; $display("FAIL glitch tick: got %0d want 10", bus.phi_tick); end
    end_access();
    n_vec++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch count: got %0d strobes want 0", obs_q.size()); end
`ifdef CPU_BUS_ERR_COUNT_EN
    n_vec++;
    if (err_count !== err_exp) begin n_fail++; $display("FAIL glitch err_count: got %h want %h", err_count, err_exp); end
`endif
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_write_abort();
    start_access(1'b0, 1'b0, 1'b1, 6'h07, 8'h11);
    wait_pc(8);
    bus.ce = 1'b1;
    end_access();
    if (err_exp != 8'hFF) err_exp = err_exp + 8'd1;
    n_vec++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL abort count: got %0d strobes want 0", obs_q.size()); end
`ifdef CPU_BUS_ERR_COUNT_EN
    n_vec++;
    if (err_count !== err_exp) begin n_fail++; $display("FAIL abort err_count: got %h want %h", err_count, err_exp); end
`endif
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_unmapped_reset();
    strobe_t e, o;
    start_access(1'b0, 1'b0, 1'b1, 6'h30, 8'hC3);
    push_wr(6'h30, 8'hC3);
    end_access();
    start_access(1'b0, 1'b0, 1'b1, 6'h31, 8'h77);
    wait_pc(7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wdata_m = '0;
    err_exp = '0;
    n_vec++;
    if ({bus.reg_rd, bus.reg_wr, bus.reg_unmapped, bus.bus_busy, bus.reg_addr, bus.reg_data, bus.phi_tick} !== 23'h0) begin
      n_fail++;
      $display("FAIL midreset outputs: got addr %h data %h tick %0d unm %b wr %b want 0",
               bus.reg_addr, bus.reg_data, bus.phi_tick, bus.reg_unmapped, bus.reg_wr);
    end
`ifdef CPU_BUS_ERR_COUNT_EN
    n_vec++;
    if (err_count !== 8'h00) begin n_fail++; $display("FAIL midreset err_count: got %h want 00", err_count); end
`endif
    wait_pc(17);
    push_wr(6'h31, 8'h77);
    end_access();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL unmapped count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_fail++; $display("FAIL unmapped strobe: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    strobe_t e, o;
    start_access(1'b0, 1'b1, 1'b1, 6'h05, 8'h00);
    push_rd(6'h05);
    end_access();
    start_access(1'b0, 1'b0, 1'b1, 6'h2E, 8'h5A);
    push_wr(6'h2E, 8'h5A);
    end_access();
    start_access(1'b0, 1'b0, 1'b1, 6'h2F, 8'h96);
    push_wr(6'h2F, 8'h96);
    end_access();
    start_access(1'b0, 1'b1, 1'b0, 6'h01, 8'h00);
    end_access();
    start_access(1'b0, 1'b1, 1'b1, 6'h3E, 8'h00);
    push_rd(6'h3E);
    end_access();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_fail++; $display("FAIL b2b strobe: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef CPU_BUS_ERR_COUNT_EN
  task automatic test_err_sat();
    strobe_t e, o;
    for (int i = 0; i < 260; i++) begin
      start_access(1'b0, 1'b0, 1'b1, 6'h08, 8'h00);
      wait_pc(8);
      bus.ce = 1'b1;
      end_access();
      if (err_exp != 8'hFF) err_exp = err_exp + 8'd1;
    end
    n_vec++;
    if (err_count !== err_exp) begin n_fail++; $display("FAIL sat err_count: got %h want %h", err_count, err_exp); end
    start_access(1'b0, 1'b0, 1'b1, 6'h3F, 8'h42);
    push_wr(6'h3F, 8'h42);
    end_access();
    err_exp = '0;
    n_vec++;
    if (err_count !== err_exp) begin n_fail++; $display("FAIL clear err_count: got %h want %h", err_count, err_exp); end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL sat count: got %0d strobes want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin n_fail++; $display("FAIL sat strobe: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst    = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_glitch();
    test_write_abort();
    test_unmapped_reset();
    test_back_to_back();
`ifdef CPU_BUS_ERR_COUNT_EN
    test_err_sat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
